// File: rtl/mult_seq_param.sv
`default_nettype none
// ============================================================================
// Module   : mult_seq_param
// Brief    : Sequential signed/unsigned multiplier, one slice partial product
//            accumulated per cycle, with start capture and a done pulse.
// Revision : 1.0 - initial release
// ============================================================================

module mult_seq_param #(
   parameter int A_WIDTH = 32,
   parameter int B_WIDTH = 32,
   parameter int A_SLICE = 8,
   parameter int B_SLICE = 16
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       start,
   input  logic                       signed_mode,
   input  logic [A_WIDTH-1:0]         a,
   input  logic [B_WIDTH-1:0]         b,
   output logic                       busy,
   output logic                       done,
   output logic [A_WIDTH+B_WIDTH-1:0] product
);

   localparam int c_NA       = A_WIDTH / A_SLICE;
   localparam int c_NB       = B_WIDTH / B_SLICE;
   localparam int c_P_WIDTH  = A_WIDTH + B_WIDTH;
   localparam int c_PP_WIDTH = A_SLICE + B_SLICE;
   localparam int c_IW       = (c_NA > 1) ? $clog2(c_NA) : 1;
   localparam int c_JW       = (c_NB > 1) ? $clog2(c_NB) : 1;
   localparam logic [c_IW-1:0] c_I_LAST = c_IW'(c_NA - 1);
   localparam logic [c_JW-1:0] c_J_LAST = c_JW'(c_NB - 1);

   if ((A_SLICE <= 0) || (B_SLICE <= 0) ||
       ((A_WIDTH % A_SLICE) != 0) || ((B_WIDTH % B_SLICE) != 0)) begin : g_param_check
      $error("mult_seq_param: A_WIDTH/B_WIDTH must be multiples of A_SLICE/B_SLICE");
   end

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2
   } state_t;

   state_t                 r_state;
   state_t                 w_state_next;
   logic [A_WIDTH-1:0]     r_a_mag;
   logic [B_WIDTH-1:0]     r_b_mag;
   logic                   r_neg;
   logic [c_IW-1:0]        r_i;
   logic [c_JW-1:0]        r_j;
   logic [c_P_WIDTH-1:0]   r_product;
   logic                   r_done;

   logic [A_WIDTH-1:0]     w_a_mag;
   logic [B_WIDTH-1:0]     w_b_mag;
   logic                   w_last;
   logic [31:0]            w_a_shift;
   logic [31:0]            w_b_shift;
   logic [A_SLICE-1:0]     w_a_slice;
   logic [B_SLICE-1:0]     w_b_slice;
   logic [c_PP_WIDTH-1:0]  w_pp;
   logic [c_P_WIDTH-1:0]   w_pp_shifted;

   // Most negative value negates to itself, which is the correct unsigned magnitude.
   assign w_a_mag = (signed_mode && a[A_WIDTH-1]) ? -a : a;
   assign w_b_mag = (signed_mode && b[B_WIDTH-1]) ? -b : b;

   assign w_last       = (r_i == c_I_LAST) && (r_j == c_J_LAST);
   assign w_a_shift    = 32'(r_i) * A_SLICE;
   assign w_b_shift    = 32'(r_j) * B_SLICE;
   assign w_a_slice    = A_SLICE'(r_a_mag >> w_a_shift);
   assign w_b_slice    = B_SLICE'(r_b_mag >> w_b_shift);
   assign w_pp         = c_PP_WIDTH'(w_a_slice) * c_PP_WIDTH'(w_b_slice);
   assign w_pp_shifted = c_P_WIDTH'(w_pp) << (w_a_shift + w_b_shift);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:  if (start) w_state_next = S_CALC;
         S_CALC:  if (w_last) w_state_next = S_FIX;
         S_FIX:   w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_a_mag   <= '0;
         r_b_mag   <= '0;
         r_neg     <= 1'b0;
         r_i       <= '0;
         r_j       <= '0;
         r_product <= '0;
         r_done    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_a_mag   <= w_a_mag;
                  r_b_mag   <= w_b_mag;
                  r_neg     <= signed_mode & (a[A_WIDTH-1] ^ b[B_WIDTH-1]);
                  r_i       <= '0;
                  r_j       <= '0;
                  r_product <= '0;
               end
            end
            S_CALC: begin
               r_product <= r_product + w_pp_shifted;
               // i is the inner index; j advances when i wraps.
               if (r_i == c_I_LAST) begin
                  r_i <= '0;
                  r_j <= (r_j == c_J_LAST) ? '0 : r_j + 1'b1;
               end else begin
                  r_i <= r_i + 1'b1;
               end
            end
            S_FIX: begin
               if (r_neg) r_product <= -r_product;
               r_done <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign busy    = (r_state != S_IDLE);
   assign done    = r_done;
   assign product = r_product;

endmodule

`default_nettype wire

// File: tb/tb_mult_seq_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_mult_seq_param
// Brief    : Vector table plus scoreboard bench for mult_seq_param (default
//            32x32 instance and a 16x8 instance with 4x8 slices).
// Revision : 1.0 - initial release
// ============================================================================

module tb_mult_seq_param;

   logic        clk;
   logic        reset_n;
   logic        start;
   logic        signed_mode;
   logic [31:0] a;
   logic [31:0] b;
   logic        busy;
   logic        done;
   logic [63:0] product;

   logic        s_start;
   logic        s_signed_mode;
   logic [15:0] s_a;
   logic [7:0]  s_b;
   logic        s_busy;
   logic        s_done;
   logic [23:0] s_product;

   int total = 0;
   int bad   = 0;
   logic [63:0] sb_q[$];

   typedef struct {
      logic        sm;
      logic [31:0] a;
      logic [31:0] b;
      logic [63:0] exp;
   } vec_t;

   vec_t vecs[12];

   mult_seq_param dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .start      (start),
      .signed_mode(signed_mode),
      .a          (a),
      .b          (b),
      .busy       (busy),
      .done       (done),
      .product    (product)
   );

   mult_seq_param #(
      .A_WIDTH(16),
      .B_WIDTH(8),
      .A_SLICE(4),
      .B_SLICE(8)
   ) dut_s (
      .clk        (clk),
      .reset_n    (reset_n),
      .start      (s_start),
      .signed_mode(s_signed_mode),
      .a          (s_a),
      .b          (s_b),
      .busy       (s_busy),
      .done       (s_done),
      .product    (s_product)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1);
   end

   function automatic logic [63:0] model(input logic sm, input logic [31:0] x, input logic [31:0] y);
      logic signed [63:0] sx;
      logic signed [63:0] sy;
      if (sm) begin
         sx = {{32{x[31]}}, x};
         sy = {{32{y[31]}}, y};
         return sx * sy;
      end
      return {32'd0, x} * {32'd0, y};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
      end
   endtask

   task automatic check_result(input string name);
      logic [63:0] e;
      if (sb_q.size() == 0) begin
         total++;
         bad++;
         $display("FAIL %s: got done with empty scoreboard required queued result", name);
      end else begin
         e = sb_q.pop_front();
         chk(name, product, e);
      end
   endtask

   // One full operation on the 32x32 instance, checking latency, busy width,
   // result, pulse width and result hold.
   task automatic run_op(input string name, input logic sm, input logic [31:0] va,
                         input logic [31:0] vb, input logic [63:0] vexp);
      int          lat;
      int          bsy;
      logic [63:0] held;
      @(negedge clk);
      start = 1'b1; signed_mode = sm; a = va; b = vb;
      sb_q.push_back(vexp);
      @(negedge clk);
      start = 1'b0; signed_mode = ~sm; a = $urandom; b = $urandom;
      lat = 1; bsy = 0;
      while (!done && lat < 40) begin
         if (busy) bsy++;
         @(negedge clk);
         lat++;
      end
      chk({name, " latency"}, 64'(lat), 64'd10);
      chk({name, " busy_cycles"}, 64'(bsy), 64'd9);
      chk({name, " busy_at_done"}, 64'(busy), 64'd0);
      if (done) check_result({name, " product"});
      held = product;
      @(negedge clk);
      chk({name, " done_width"}, 64'(done), 64'd0);
      chk({name, " hold"}, product, held);
   endtask

   initial begin
      int          lat;
      int          bsy;
      logic        seen;
      logic [63:0] first_exp;
      logic [23:0] s_exp;

      reset_n = 1'b0; start = 1'b0; signed_mode = 1'b0; a = '0; b = '0;
      s_start = 1'b0; s_signed_mode = 1'b0; s_a = '0; s_b = '0;

      vecs[0] = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001};
      vecs[1] = '{1'b1, 32'hFFFF_FFFD, 32'h0000_0007, 64'hFFFF_FFFF_FFFF_FFEB};
      vecs[2] = '{1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000};
      vecs[3] = '{1'b0, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000};
      vecs[4] = '{1'b1, 32'h8000_0000, 32'h0000_0001, 64'hFFFF_FFFF_8000_0000};
      vecs[5] = '{1'b0, 32'h0000_0000, 32'h1234_5678, 64'h0};
      vecs[6] = '{1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h1};
      vecs[7] = '{1'b1, 32'h7FFF_FFFF, 32'h8000_0000, 64'hC000_0000_8000_0000};
      for (int k = 8; k < 12; k++) begin
         vecs[k].sm  = k[0];
         vecs[k].a   = $urandom;
         vecs[k].b   = $urandom;
         vecs[k].exp = model(vecs[k].sm, vecs[k].a, vecs[k].b);
      end

      repeat (3) @(negedge clk);
      chk("reset busy", 64'(busy), 64'd0);
      chk("reset done", 64'(done), 64'd0);
      chk("reset product", product, 64'd0);
      chk("reset s_busy", 64'(s_busy), 64'd0);
      chk("reset s_product", 64'(s_product), 64'd0);
      reset_n = 1'b1;
      @(negedge clk);
      chk("post reset busy", 64'(busy), 64'd0);

      for (int k = 0; k < 12; k++) begin
         run_op($sformatf("vec%0d", k), vecs[k].sm, vecs[k].a, vecs[k].b, vecs[k].exp);
      end

      // Small instance: 16x8 with 4x8 slices, NA*NB+1 = 5 busy cycles.
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         s_start = 1'b1; s_signed_mode = 1'b0;
         s_a = (k == 0) ? 16'hABCD : 16'($urandom);
         s_b = (k == 0) ? 8'h12 : 8'($urandom);
         s_exp = {8'd0, s_a} * {16'd0, s_b};
         if (k == 0) chk("small table const", 64'(s_exp), 64'h000C_146A);
         @(negedge clk);
         s_start = 1'b0; s_a = 16'($urandom);
         lat = 1; bsy = 0;
         while (!s_done && lat < 30) begin
            if (s_busy) bsy++;
            @(negedge clk);
            lat++;
         end
         chk($sformatf("small%0d latency", k), 64'(lat), 64'd6);
         chk($sformatf("small%0d busy_cycles", k), 64'(bsy), 64'd5);
         chk($sformatf("small%0d product", k), 64'(s_product), 64'(s_exp));
      end

      // Start held high across an operation, second start taken in the done cycle.
      @(negedge clk);
      start = 1'b1; signed_mode = 1'b0; a = 32'h1234_5678; b = 32'h9ABC_DEF0;
      first_exp = model(1'b0, 32'h1234_5678, 32'h9ABC_DEF0);
      sb_q.push_back(first_exp);
      @(negedge clk);
      lat = 1;
      while (!done && lat < 40) begin
         signed_mode = $urandom; a = $urandom; b = $urandom;
         @(negedge clk);
         lat++;
      end
      chk("held latency", 64'(lat), 64'd10);
      if (done) check_result("held product");
      signed_mode = 1'b1; a = 32'hFFFF_FF00; b = 32'h0001_0003;
      sb_q.push_back(model(1'b1, 32'hFFFF_FF00, 32'h0001_0003));
      @(negedge clk);
      start = 1'b0;
      chk("b2b busy", 64'(busy), 64'd1);
      lat = 1;
      while (!done && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      chk("b2b latency", 64'(lat), 64'd10);
      if (done) check_result("b2b product");

      // Asynchronous reset during the fourth CALC cycle.
      @(negedge clk);
      start = 1'b1; signed_mode = 1'b0; a = 32'hDEAD_BEEF; b = 32'hCAFE_F00D;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      chk("abort busy before", 64'(busy), 64'd1);
      reset_n = 1'b0;
      #1;
      chk("abort busy", 64'(busy), 64'd0);
      chk("abort done", 64'(done), 64'd0);
      chk("abort product", product, 64'd0);
      @(negedge clk);
      reset_n = 1'b1;
      seen = 1'b0;
      repeat (15) begin
         @(negedge clk);
         if (done) seen = 1'b1;
      end
      chk("abort no done", 64'(seen), 64'd0);
      run_op("after abort", 1'b1, 32'hDEAD_BEEF, 32'h0000_0123,
             model(1'b1, 32'hDEAD_BEEF, 32'h0000_0123));

      chk("scoreboard empty", 64'(sb_q.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/mult_seq_param.md
Name: mult_seq_param

Overview:
- Parametrised sequential multiplier: a self-contained controller plus datapath.
- Computes A_WIDTH x B_WIDTH products by accumulating A_SLICE x B_SLICE partial products, one per cycle.
- Adds a signed/unsigned mode, operand capture on start, and a done pulse.
- Drop-in arithmetic unit for datapaths needing a multiplier narrower or wider than 32x32.

Parameters:
- A_WIDTH, 32, multiplicand width; must be a multiple of A_SLICE.
- B_WIDTH, 32, multiplier width; must be a multiple of B_SLICE.
- A_SLICE, 8, bits of A consumed per partial product.
- B_SLICE, 16, bits of B consumed per partial product.
- Derived: NA = A_WIDTH/A_SLICE; NB = B_WIDTH/B_SLICE; P_WIDTH = A_WIDTH+B_WIDTH.

Ports:
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  request; accepted only when busy=0
- signed_mode  in  1  1 = two's-complement operands, 0 = unsigned; sampled with start
- a  in  A_WIDTH  multiplicand; sampled with start
- b  in  B_WIDTH  multiplier; sampled with start
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse; product is final
- product  out  P_WIDTH  product register

Behaviour:
- Reset (reset_n=0, asynchronous): state=IDLE; busy=0, done=0, product=0; operand registers and counters are cleared.
- Reset mid-operation aborts the operation immediately. No done is produced for it.
- States: IDLE, CALC, FIX.
- IDLE:
  - When start=1 at a rising edge (cycle T), capture signed_mode, |a| and |b|, and neg = signed_mode & (a_msb ^ b_msb).
  - In the same edge: clear product to 0, set i=0, j=0, go to CALC.
  - For signed_mode=1 the magnitude is the two's-complement negation when the MSB is 1. The value -2^(W-1) yields 2^(W-1), which fits in W unsigned bits.
- CALC (NA*NB cycles, T+1 .. T+NA*NB):
  - Each cycle: product += (A_slice[i] * B_slice[j]) << (i*A_SLICE + j*B_SLICE).
  - Slices are taken from the captured magnitudes. Partial product width is A_SLICE+B_SLICE. The sum never overflows P_WIDTH.
  - Ordering: j is the outer index and i the inner one. i increments every cycle; on i=NA-1, i wraps to 0 and j increments.
  - When i=NA-1 and j=NB-1, go to FIX.
- FIX (1 cycle, T+NA*NB+1): if neg=1, product <= -product (P_WIDTH two's complement); otherwise product is held. Then go to IDLE and set done=1.
- busy=1 in CALC and FIX, i.e. exactly NA*NB+1 cycles. busy is 0 in IDLE.
- done=1 for exactly one cycle (T+NA*NB+2), while in IDLE with busy=0. done is registered.
- product holds its final value from the done cycle until the next accepted start clears it.
- product is not meaningful while busy=1.
- start while busy=1 is ignored: no effect on state, operands or count.
- start asserted in the done cycle is accepted, allowing back-to-back operations with a period of NA*NB+2 cycles.
- Zero operands still take full latency; there is no early termination.
- signed_mode=0 with the MSB set is treated as a large unsigned value, and neg=0.
- Invalid parameters (non-divisible widths) must trigger an elaboration-time error.

Test Plan:
- Default params, unsigned, a=0xFFFFFFFF, b=0xFFFFFFFF -> busy high 9 cycles; done pulses at T+10; product=0xFFFFFFFE00000001.
- Default params, signed, a=0xFFFFFFFD (-3), b=0x00000007 -> product=0xFFFFFFFFFFFFFFEB (-21).
- Default params, signed, a=b=0x80000000 -> product=0x4000000000000000. The same operands unsigned -> product=0x4000000000000000; the same operands with a signed, b=0x00000001 -> product=0xFFFFFFFF80000000.
- Params A_WIDTH=16, B_WIDTH=8, A_SLICE=4, B_SLICE=8, unsigned, a=0xABCD, b=0x12 -> busy 5 cycles; product=0x000C146A at the done pulse.
- Default params: start held high through an operation with a changing on busy cycles -> result uses the operands captured at T only. A second start in the done cycle is accepted; the second result is correct and its done is 10 cycles later.
- Default params: assert reset_n=0 at CALC cycle 4 -> busy, done and product go to 0 asynchronously and no done pulse follows. A fresh start after release gives the correct product.
